meta_write_buffer: RTL and testbench

Buffers L1 data-cache metadata write requests after the meta-write arbiter and drains them in order into the tag-array write port. Decouples the arbiter from tag-array port contention. Flags read-after-write hazards so the tag-read pipeline can replay a lookup whose set has a pending metadata update. Sits between the 8-way meta-write arbiter output and the tag/coherence-state SRAM wrapper.

---
 rtl/meta_write_buffer.sv | 134 +++++++++++++
 tb/tb_meta_write_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_write_buffer.sv
// In-order FIFO of tag/coh-state writes with a read-after-write hazard flag; 1-cycle min latency, full throughput.
// io_in_ready drops only when full (no pass-through); META_WB_COALESCE_EN merges repeat writes into a queued non-head entry.
`timescale 1ns/1ps
module meta_write_buffer #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  parameter int WAYS  = 8,
  parameter int TAG_W = 20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [IDX_W-1:0]         io_in_bits_idx,
  input  logic [WAYS-1:0]          io_in_bits_way_en,
  input  logic [1:0]               io_in_bits_data_coh_state,
  input  logic [TAG_W-1:0]         io_in_bits_data_tag,
  output logic                     io_write_valid,
  input  logic                     io_write_ready,
  output logic [IDX_W-1:0]         io_write_bits_idx,
  output logic [WAYS-1:0]          io_write_bits_way_en,
  output logic [1:0]               io_write_bits_data_coh_state,
  output logic [TAG_W-1:0]         io_write_bits_data_tag,
  input  logic                     io_read_valid,
  input  logic [IDX_W-1:0]         io_read_idx,
  output logic                     io_read_hazard,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic                     io_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [WAYS-1:0]  way_q [DEPTH];
  logic [1:0]       coh_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, off;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq, alloc;
  logic [DEPTH-1:0] occ, rd_match;

  assign io_in_ready    = reset & (count_q != CNT_W'(DEPTH));
  assign io_write_valid = reset & (count_q != '0);
  assign enq            = io_in_valid & io_in_ready;
  assign deq            = io_write_valid & io_write_ready;

  assign io_write_bits_idx            = idx_q[head_q];
  assign io_write_bits_way_en         = way_q[head_q];
  assign io_write_bits_data_coh_state = coh_q[head_q];
  assign io_write_bits_data_tag       = tag_q[head_q];

  assign io_count = reset ? count_q : '0;
  assign io_empty = (io_count == '0);

  // An entry is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    occ      = '0;
    rd_match = '0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - head_q;
      occ[i]      = {1'b0, off} < count_q;
      rd_match[i] = occ[i] & (idx_q[i] == io_read_idx);
    end
  end

  assign io_read_hazard = io_read_valid &
                          ((reset & (|rd_match)) | (enq & (io_in_bits_idx == io_read_idx)));

`ifdef META_WB_COALESCE_EN
  logic             coal_hit;
  logic [PTR_W-1:0] coal_ptr, scan_ptr;

  // Scan oldest to youngest past the head so the last hit is the youngest match.
  always_comb begin
    coal_hit = 1'b0;
    coal_ptr = '0;
    scan_ptr = '0;
    for (int k = 1; k < DEPTH; k++) begin
      scan_ptr = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (idx_q[scan_ptr] == io_in_bits_idx) &&
          (way_q[scan_ptr] == io_in_bits_way_en)) begin
        coal_hit = 1'b1;
        coal_ptr = scan_ptr;
      end
    end
  end

  assign alloc = enq & ~coal_hit;
`else
  assign alloc = enq;
`endif

  always_comb begin
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q + PTR_W'(alloc);
    count_d = count_q;
    if (alloc && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!alloc && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is not reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (alloc) begin
      idx_q[tail_q] <= io_in_bits_idx;
      way_q[tail_q] <= io_in_bits_way_en;
      coh_q[tail_q] <= io_in_bits_data_coh_state;
      tag_q[tail_q] <= io_in_bits_data_tag;
    end
`ifdef META_WB_COALESCE_EN
    if (enq && coal_hit) begin
      coh_q[coal_ptr] <= io_in_bits_data_coh_state;
      tag_q[coal_ptr] <= io_in_bits_data_tag;
    end
`endif
  end

endmodule

// File: tb/tb_meta_write_buffer.sv
// Directed bench for meta_write_buffer: scoreboard of expected tag-array writes plus direct status checks.
`timescale 1ns/1ps
module tb_meta_write_buffer;
  typedef struct packed {
    logic [5:0]  idx;
    logic [7:0]  way;
    logic [1:0]  coh;
    logic [19:0] tag;
  } wr_t;

  logic        clock, reset;
  logic        io_in_valid, io_in_ready;
  logic [5:0]  io_in_bits_idx;
  logic [7:0]  io_in_bits_way_en;
  logic [1:0]  io_in_bits_data_coh_state;
  logic [19:0] io_in_bits_data_tag;
  logic        io_write_valid, io_write_ready;
  logic [5:0]  io_write_bits_idx;
  logic [7:0]  io_write_bits_way_en;
  logic [1:0]  io_write_bits_data_coh_state;
  logic [19:0] io_write_bits_data_tag;
  logic        io_read_valid, io_read_hazard;
  logic [5:0]  io_read_idx;
  logic [2:0]  io_count;
  logic        io_empty;

  int  total = 0;
  int  bad   = 0;
  wr_t sb[$];
  wr_t held;
  logic stall_q = 1'b0;

  meta_write_buffer #(.DEPTH(4), .IDX_W(6), .WAYS(8), .TAG_W(20)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_idx(io_in_bits_idx), .io_in_bits_way_en(io_in_bits_way_en),
    .io_in_bits_data_coh_state(io_in_bits_data_coh_state), .io_in_bits_data_tag(io_in_bits_data_tag),
    .io_write_valid(io_write_valid), .io_write_ready(io_write_ready),
    .io_write_bits_idx(io_write_bits_idx), .io_write_bits_way_en(io_write_bits_way_en),
    .io_write_bits_data_coh_state(io_write_bits_data_coh_state), .io_write_bits_data_tag(io_write_bits_data_tag),
    .io_read_valid(io_read_valid), .io_read_idx(io_read_idx), .io_read_hazard(io_read_hazard),
    .io_count(io_count), .io_empty(io_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clock);
  endtask

  task automatic send(input logic [5:0] idx, input logic [7:0] way, input logic [1:0] coh, input logic [19:0] tag);
    io_in_valid = 1'b1;
    io_in_bits_idx = idx;
    io_in_bits_way_en = way;
    io_in_bits_data_coh_state = coh;
    io_in_bits_data_tag = tag;
  endtask

  task automatic idle;
    io_in_valid = 1'b0;
  endtask

  // Inputs only change just after a rising edge, so the falling edge sees what the next edge will act on.
  always @(negedge clock) begin
    wr_t got, n, e;
    logic hit;
    if (!reset) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (io_in_valid && io_in_ready) begin
        n = '{io_in_bits_idx, io_in_bits_way_en, io_in_bits_data_coh_state, io_in_bits_data_tag};
        hit = 1'b0;
`ifdef META_WB_COALESCE_EN
        for (int j = sb.size() - 1; j >= 1; j--) begin
          if (!hit && sb[j].idx == n.idx && sb[j].way == n.way) begin
            sb[j].coh = n.coh;
            sb[j].tag = n.tag;
            hit = 1'b1;
          end
        end
`endif
        if (!hit) sb.push_back(n);
      end
      got = '{io_write_bits_idx, io_write_bits_way_en, io_write_bits_data_coh_state, io_write_bits_data_tag};
      if (stall_q && io_write_valid) chk("hold_stable", got, held);
      if (io_write_valid && io_write_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_write observed=%0h expected=none", got);
        end else begin
          e = sb.pop_front();
          chk("drain_entry", got, e);
        end
      end
      stall_q = io_write_valid && !io_write_ready;
      held = got;
    end
    chk("count_bound", io_count <= 3'd4, 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; io_in_valid = 1'b0; io_in_bits_idx = '0; io_in_bits_way_en = '0;
    io_in_bits_data_coh_state = '0; io_in_bits_data_tag = '0;
    io_write_ready = 1'b0; io_read_valid = 1'b1; io_read_idx = '0;
    tick; tick;
    at_neg;
    chk("rst_in_ready", io_in_ready, 0);
    chk("rst_write_valid", io_write_valid, 0);
    chk("rst_count", io_count, 0);
    chk("rst_empty", io_empty, 1);
    chk("rst_hazard", io_read_hazard, 0);
    tick; reset = 1'b1; io_read_valid = 1'b0;
    at_neg;
    chk("rel_in_ready", io_in_ready, 1);
    chk("rel_empty", io_empty, 1);

    // Single request, 1-cycle latency.
    tick; io_write_ready = 1'b1; send(6'd5, 8'h04, 2'd2, 20'hABCDE);
    at_neg; chk("lat_wv_before", io_write_valid, 0);
    tick; idle;
    at_neg;
    chk("lat_wv", io_write_valid, 1);
    chk("lat_idx", io_write_bits_idx, 5);
    chk("lat_way", io_write_bits_way_en, 8'h04);
    chk("lat_coh", io_write_bits_data_coh_state, 2);
    chk("lat_tag", io_write_bits_data_tag, 20'hABCDE);
    chk("lat_count", io_count, 1);
    tick;
    at_neg;
    chk("lat_count_after", io_count, 0);
    chk("lat_wv_after", io_write_valid, 0);

    // Fill to full, then drain in order.
    tick; io_write_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(6'(i), 8'h01, 2'd1, 20'(i + 100));
      at_neg;
      if (i < 4) chk("fill_ready", io_in_ready, 1);
      else begin
        chk("full_ready", io_in_ready, 0);
        chk("full_count", io_count, 4);
      end
      tick;
    end
    idle; io_write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg;
      chk("drain_idx", io_write_bits_idx, i);
      chk("drain_ready", io_in_ready, (i == 0) ? 0 : 1);
      tick;
    end
    at_neg; chk("drain_count", io_count, 0);

    // Full with simultaneous enqueue attempt and dequeue: no pass-through.
    tick; io_write_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(6'(20 + i), 8'h02, 2'd3, 20'(200 + i));
      tick;
    end
    send(6'd30, 8'h02, 2'd3, 20'd300); io_write_ready = 1'b1;
    at_neg;
    chk("full_deq_ready", io_in_ready, 0);
    chk("full_deq_count", io_count, 4);
    tick; idle; io_write_ready = 1'b0;
    at_neg;
    chk("full_deq_count_after", io_count, 3);
    chk("full_deq_head", io_write_bits_idx, 21);
    tick; io_write_ready = 1'b1;
    tick; tick; tick; io_write_ready = 1'b0;
    at_neg; chk("full_deq_drained", io_count, 0);

    // Hazard detection.
    tick; send(6'd9, 8'h10, 2'd1, 20'h9);
    tick; idle; io_read_valid = 1'b1; io_read_idx = 6'd9;
    at_neg; chk("haz_pending", io_read_hazard, 1);
    tick; send(6'd10, 8'h20, 2'd1, 20'hA); io_read_idx = 6'd10;
    at_neg; chk("haz_incoming", io_read_hazard, 1);
    tick; idle; io_read_idx = 6'd11;
    at_neg; chk("haz_none", io_read_hazard, 0);
    tick; io_read_valid = 1'b0; io_read_idx = 6'd9;
    at_neg; chk("haz_no_valid", io_read_hazard, 0);
    tick; io_read_valid = 1'b1; io_write_ready = 1'b1;
    at_neg; chk("haz_head_deq", io_read_hazard, 1);
    tick;
    at_neg; chk("haz_after_deq", io_read_hazard, 0);
    tick; io_read_valid = 1'b0; io_write_ready = 1'b0;
    at_neg; chk("haz_drained", io_count, 0);

    // Reset with entries pending.
    tick; send(6'd40, 8'h01, 2'd1, 20'h40);
    tick; send(6'd41, 8'h01, 2'd1, 20'h41);
    tick; send(6'd42, 8'h01, 2'd1, 20'h42);
    tick; idle;
    at_neg; chk("pre_rst_count", io_count, 3);
    tick; reset = 1'b0; io_read_valid = 1'b1; io_read_idx = 6'd40; io_write_ready = 1'b1;
    at_neg;
    chk("midrst_wv", io_write_valid, 0);
    chk("midrst_hazard", io_read_hazard, 0);
    chk("midrst_in_ready", io_in_ready, 0);
    tick; reset = 1'b1; io_read_valid = 1'b0;
    at_neg;
    chk("postrst_wv", io_write_valid, 0);
    chk("postrst_empty", io_empty, 1);
    chk("postrst_count", io_count, 0);
    chk("postrst_in_ready", io_in_ready, 1);
    tick; tick;
    at_neg; chk("postrst_no_write", io_write_valid, 0);

    // Repeat writes to the same way: coalesce into non-head entries when enabled.
    tick; io_write_ready = 1'b0; send(6'd3, 8'h01, 2'd1, 20'h1);
    tick; send(6'd4, 8'h02, 2'd1, 20'h44);
    tick; send(6'd3, 8'h01, 2'd1, 20'h2);
    tick; idle;
    at_neg; chk("co_head_match_alloc", io_count, 3);
    tick; send(6'd4, 8'h02, 2'd3, 20'h55);
    tick; idle;
`ifdef META_WB_COALESCE_EN
    at_neg; chk("co_count", io_count, 3);
`else
    at_neg; chk("co_count", io_count, 4);
`endif
    tick; io_write_ready = 1'b1;
    at_neg;
    chk("co_first_idx", io_write_bits_idx, 3);
    chk("co_first_tag", io_write_bits_data_tag, 20'h1);
    tick;
    at_neg;
    chk("co_second_idx", io_write_bits_idx, 4);
`ifdef META_WB_COALESCE_EN
    chk("co_second_tag", io_write_bits_data_tag, 20'h55);
`else
    chk("co_second_tag", io_write_bits_data_tag, 20'h44);
`endif
    tick; tick;
`ifndef META_WB_COALESCE_EN
    tick;
`endif
    at_neg; chk("co_drained", io_count, 0);
    chk("co_sb_empty", sb.size(), 0);

    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
